// File: rtl/dm_cache.sv
// dm_cache: direct-mapped write-through no-write-allocate blocking cache
module dm_cache #(
  parameter int LINES = 64,
  parameter int LINE_WORDS = 4,
  parameter logic [3:0] UNCACHED_NIBBLE = 4'h8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rw,
  output logic [29:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);
  localparam int WO = $clog2(LINE_WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - WO - IW;
  typedef enum logic [2:0] {READY, MISS_REQ, REFILL, WRITE_WAIT, UNC_REQ, UNC_WAIT, REPLAY} state_t;
  state_t state, state_n;
  logic p_valid, p_unc, hit, accept, fill_done, byp, unused_addr;
  logic [29:0] p_addr;
  logic [31:0] p_din, cap, rdata, arr_word, arr_wd, byp_data, byp_mask;
  logic [3:0] p_we, arr_be, byp_be;
  logic [IW+WO-1:0] arr_wa, ra;
  logic [WO-1:0] beat, p_word;
  logic [IW-1:0] p_idx;
  logic [TW-1:0] p_tag;
  logic [LINES-1:0] valid;
  logic [TW-1:0] tags [LINES];
  logic [31:0] data [LINES*LINE_WORDS];
  assign unused_addr = ^addr[1:0];
  assign p_word = p_addr[WO-1:0];
  assign p_idx = p_addr[WO+:IW];
  assign p_tag = p_addr[29-:TW];
  assign ra = addr[2+:IW+WO];
  assign hit = !p_unc && valid[p_idx] && tags[p_idx] == p_tag;
  assign accept = !stall && (re || |we);
  // a store landing on the word being read at the same edge is forwarded here
  assign byp_mask = {{8{byp_be[3]}}, {8{byp_be[2]}}, {8{byp_be[1]}}, {8{byp_be[0]}}};
  assign arr_word = byp ? (byp_data & byp_mask) | (rdata & ~byp_mask) : rdata;
  always_comb begin
    state_n = state;
    stall = 1'b1;
    dout = '0;
    mem_req_valid = 1'b0;
    mem_req_rw = |p_we;
    mem_req_addr = (|p_we || p_unc) ? p_addr : {p_tag, p_idx, {WO{1'b0}}};
    mem_req_data = p_din;
    mem_req_mask = p_we;
    arr_be = '0;
    arr_wa = {p_idx, p_word};
    arr_wd = p_din;
    fill_done = 1'b0;
    case (state)
      READY:
        if (!p_valid) stall = 1'b0;
        else if (|p_we) begin
          mem_req_valid = 1'b1;
          arr_be = hit ? p_we : '0;
          stall = !mem_req_ready;
          state_n = mem_req_ready ? READY : WRITE_WAIT;
        end else if (p_unc) state_n = UNC_REQ;
        else if (hit) begin
          stall = 1'b0;
          dout = arr_word;
        end else state_n = MISS_REQ;
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        state_n = mem_req_ready ? REFILL : MISS_REQ;
      end
      REFILL:
        if (mem_resp_valid) begin
          arr_be = '1;
          arr_wa = {p_idx, beat};
          arr_wd = mem_resp_data;
          fill_done = beat == WO'(LINE_WORDS - 1);
          state_n = fill_done ? REPLAY : REFILL;
        end
      UNC_REQ: begin
        mem_req_valid = 1'b1;
        state_n = mem_req_ready ? UNC_WAIT : UNC_REQ;
      end
      UNC_WAIT: state_n = mem_resp_valid ? REPLAY : UNC_WAIT;
      WRITE_WAIT: begin
        mem_req_valid = 1'b1;
        stall = !mem_req_ready;
        state_n = mem_req_ready ? READY : WRITE_WAIT;
      end
      REPLAY: begin
        stall = 1'b0;
        dout = cap;
        state_n = READY;
      end
      default: state_n = READY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= READY;
      p_valid <= 1'b0;
      valid <= '0;
      beat <= '0;
      byp <= 1'b0;
    end else begin
      state <= state_n;
      if (!stall) p_valid <= accept;
      if (state == MISS_REQ) beat <= '0;
      else if (state == REFILL && mem_resp_valid) beat <= beat + 1'b1;
      if (fill_done) valid[p_idx] <= 1'b1;
      byp <= |arr_be && arr_wa == ra;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      p_addr <= addr[31:2];
      p_we <= we;
      p_din <= din;
      p_unc <= addr[31:28] == UNCACHED_NIBBLE;
    end
    if (fill_done) tags[p_idx] <= p_tag;
    if (mem_resp_valid && ((state == REFILL && beat == p_word) || state == UNC_WAIT)) cap <= mem_resp_data;
    byp_be <= arr_be;
    byp_data <= arr_wd;
    for (int i = 0; i < 4; i++) if (arr_be[i]) data[arr_wa][8*i+:8] <= arr_wd[8*i+:8];
    rdata <= data[ra];
  end
endmodule
